// File: rtl/hazard_control.sv
// hazard_control: stall/flush sequencer for the 5-stage core.
// Load-use bubbles, dcache freeze, deferred redirects, halt, perf counters.
module hazard_control #(
  parameter int STALL_W = 16,
  parameter int FLUSH_W = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               ihit,
  input  logic               dhit,
  input  logic               exmem_dreq,
  input  logic               idex_memread,
  input  logic [4:0]         idex_rt,
  input  logic [4:0]         ifid_rs,
  input  logic [4:0]         ifid_rt,
  input  logic               ifid_uses_rt,
  input  logic               exmem_redirect,
  input  logic               memwb_halt,
  output logic               pc_en,
  output logic               ifid_en,
  output logic               idex_en,
  output logic               exmem_en,
  output logic               memwb_en,
  output logic               ifid_flush,
  output logic               idex_flush,
  output logic               exmem_flush,
  output logic               memwb_flush,
  output logic               halted,
  output logic [STALL_W-1:0] stall_cnt,
  output logic [FLUSH_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               pend_q, pend_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [FLUSH_W-1:0] flush_q, flush_d;

  logic dstall, istall, luse, redir;
  logic rt_hit;

  assign dstall = exmem_dreq & ~dhit;
  assign istall = ~ihit;
  assign rt_hit = ifid_uses_rt & (idex_rt == ifid_rt);
  assign luse   = idex_memread & (idex_rt != 5'd0) &
                  ((idex_rt == ifid_rs) | rt_hit);
  assign redir  = exmem_redirect | pend_q;

  // Priority decode of latch enables/flushes and next state
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    halted      = 1'b0;
    state_d     = RUN;
    pend_d      = pend_q;
    flush_d     = flush_q;
    stall_d     = stall_q;
    if (RST) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else begin
      priority case (1'b1)
        (state_q == HALTED): begin
          halted  = 1'b1;
          state_d = HALTED;
        end
        memwb_halt: begin
          memwb_en = 1'b1;
          state_d  = HALTED;
        end
        dstall: begin
          memwb_en    = 1'b1;
          memwb_flush = 1'b1;
          state_d     = DWAIT;
          if (exmem_redirect) pend_d = 1'b1;
        end
        redir: begin
          pc_en       = 1'b1;
          ifid_en     = 1'b1;
          idex_en     = 1'b1;
          exmem_en    = 1'b1;
          memwb_en    = 1'b1;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          pend_d      = 1'b0;
          if (~&flush_q) flush_d = flush_q + 1'b1;
        end
        luse: begin
          idex_en    = 1'b1;
          idex_flush = 1'b1;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
        end
        istall: begin
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
          idex_en    = 1'b1;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
        end
        default: begin
          pc_en    = 1'b1;
          ifid_en  = 1'b1;
          idex_en  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
        end
      endcase
      if (!pc_en && state_q != HALTED && ~&stall_q)
        stall_d = stall_q + 1'b1;
    end
  end

  // State, pending redirect and saturating counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      pend_q  <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule
